// File: rtl/dac_ramp_seq.sv
// Ramp/triangle sequencer feeding the AD5331 DAC control register write port.
// Software programs CTRL/CFG/TIME over the PCI bus; the FSM paces writes on dac1_busy.
module dac_ramp_seq #(
  parameter int TMO_CYC = 4,
  parameter int DWELL_W = 16
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         valid_pci,
  input  logic         rd_wr,
  input  logic [31:0]  ad_to_tuvv,
  output logic [31:0]  ad_from_tuvv,
  input  logic         seq_ctrl_sel,
  input  logic         seq_cfg_sel,
  input  logic         seq_time_sel,
  input  logic         dac1_busy,
  output logic         dac_wr_valid,
  output logic [31:0]  dac_wr_data,
  output logic         seq_active
);

  localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_DWELL} state_t;
  state_t state, state_nxt;

  logic               run, loop_en, tri_en, dir, ret, done, err;
  logic [21:0]        tmpl;
  logic [9:0]         cfg_start, cfg_end, cur_code;
  logic [5:0]         cfg_step;
  logic [DWELL_W-1:0] dwell_cyc, dwell_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [31:0]        wr_data_q;

  logic        wr_ctrl, wr_cfg, wr_time;
  logic [10:0] step_eff, sum, diff;
  logic [9:0]  target, nxt_tgt, nxt_code;
  logic        nxt_dir, nxt_ret, at_target, ramp_end, timeout, dwell_done;

  assign wr_ctrl = seq_ctrl_sel & valid_pci & rd_wr;
  assign wr_cfg  = seq_cfg_sel  & valid_pci & rd_wr;
  assign wr_time = seq_time_sel & valid_pci & rd_wr;

  assign seq_active   = (state != S_IDLE);
  assign dac_wr_valid = (state == S_ISSUE);
  assign dac_wr_data  = wr_data_q;

  // ret marks the return leg of a triangle, where the target becomes start.
  assign target     = ret ? cfg_start : cfg_end;
  assign at_target  = (cur_code == target);
  assign ramp_end   = at_target & ~loop_en & (~tri_en | ret | (cfg_start == cfg_end));
  assign step_eff   = {5'd0, (cfg_step == 6'd0) ? 6'd1 : cfg_step};
  assign timeout    = (tmo_cnt == TMO_LAST);
  assign dwell_done = (dwell_cnt == dwell_cyc);

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    nxt_dir = dir;
    nxt_ret = ret;
    nxt_tgt = target;
    if (at_target && tri_en) begin
      nxt_dir = ~dir;
      nxt_ret = ~ret;
      nxt_tgt = ret ? cfg_end : cfg_start;
    end
    // 11-bit arithmetic so a step past 0x3FF or below 0 is caught before clamping.
    sum  = {1'b0, cur_code} + step_eff;
    diff = {1'b0, cur_code} - step_eff;
    if (!nxt_dir) nxt_code = (sum >= {1'b0, nxt_tgt}) ? nxt_tgt : sum[9:0];
    else          nxt_code = (diff[10] || (diff[9:0] < nxt_tgt)) ? nxt_tgt : diff[9:0];
    if (at_target && !tri_en) begin
      nxt_code = cfg_start;
      nxt_ret  = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (run) state_nxt = S_ISSUE;
      S_ISSUE:   state_nxt = S_WAIT_HI;
      S_WAIT_HI: if (dac1_busy) state_nxt = S_WAIT_LO;
                 else if (timeout) state_nxt = S_IDLE;
      S_WAIT_LO: if (!dac1_busy) state_nxt = (!run || ramp_end) ? S_IDLE : S_DWELL;
      S_DWELL:   if (dwell_done) state_nxt = S_ISSUE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      run       <= 1'b0;
      loop_en   <= 1'b0;
      tri_en    <= 1'b0;
      tmpl      <= '0;
      cfg_start <= '0;
      cfg_end   <= '0;
      cfg_step  <= '0;
      dwell_cyc <= '0;
      cur_code  <= '0;
      dir       <= 1'b0;
      ret       <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      wr_data_q <= '0;
      tmo_cnt   <= '0;
      dwell_cnt <= '0;
    end else begin
      if (wr_ctrl) begin
        loop_en <= ad_to_tuvv[1];
        tri_en  <= ad_to_tuvv[2];
        if (!seq_active) begin
          run  <= ad_to_tuvv[0];
          tmpl <= ad_to_tuvv[31:10];
        end else if (!ad_to_tuvv[0]) begin
          run <= 1'b0;
        end
      end
      if (wr_cfg && !seq_active) begin
        cfg_start <= ad_to_tuvv[9:0];
        cfg_end   <= ad_to_tuvv[19:10];
        cfg_step  <= ad_to_tuvv[25:20];
      end
      if (wr_time && !seq_active) dwell_cyc <= ad_to_tuvv[DWELL_W-1:0];

      tmo_cnt   <= (state == S_WAIT_HI) ? tmo_cnt + 1'b1 : '0;
      dwell_cnt <= (state == S_DWELL)   ? dwell_cnt + 1'b1 : '0;

      unique case (state)
        S_IDLE: if (run) begin
          cur_code  <= cfg_start;
          wr_data_q <= {tmpl, cfg_start};
          dir       <= (cfg_end < cfg_start);
          ret       <= 1'b0;
          done      <= 1'b0;
          err       <= 1'b0;
        end
        S_WAIT_HI: if (!dac1_busy && timeout) begin
          err <= 1'b1;
          run <= 1'b0;
        end
        S_WAIT_LO: if (!dac1_busy && run && ramp_end) begin
          done <= 1'b1;
          run  <= 1'b0;
        end
        S_DWELL: if (dwell_done) begin
          cur_code  <= nxt_code;
          dir       <= nxt_dir;
          ret       <= nxt_ret;
          wr_data_q <= {tmpl, nxt_code};
        end
        default: ;
      endcase
    end
  end

  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    if (seq_ctrl_sel)      rd_mux = {18'd0, dir, err, done, seq_active, cur_code};
    else if (seq_cfg_sel)  rd_mux = {6'd0, cfg_step, cfg_end, cfg_start};
    else if (seq_time_sel) rd_mux = 32'(dwell_cyc);
  end

  assign ad_from_tuvv = (!rd_wr && (seq_ctrl_sel || seq_cfg_sel || seq_time_sel)) ? rd_mux : 'z;

endmodule

// File: tb/tb_dac_ramp_seq.sv
// Scoreboard bench for dac_ramp_seq: stimulus pushes expected DAC words,
// a negedge monitor pops and compares each strobe; register readbacks are checked inline.
module tb_dac_ramp_seq;
  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic        valid_pci = 1'b0;
  logic        rd_wr = 1'b0;
  logic [31:0] ad_to_tuvv = '0;
  wire  [31:0] ad_from_tuvv;
  logic        seq_ctrl_sel = 1'b0, seq_cfg_sel = 1'b0, seq_time_sel = 1'b0;
  logic        dac1_busy;
  logic        dac_wr_valid;
  logic [31:0] dac_wr_data;
  logic        seq_active;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [21:0] tb_tmpl = 22'h2A5A5;
  logic        busy_en = 1'b1;
  int          busy_cnt = 0;
  logic [31:0] rd;

  localparam int SEL_CTRL = 0, SEL_CFG = 1, SEL_TIME = 2;

  dac_ramp_seq #(.TMO_CYC(4), .DWELL_W(16)) dut (
    .clk(clk), .rst_(rst_), .valid_pci(valid_pci), .rd_wr(rd_wr),
    .ad_to_tuvv(ad_to_tuvv), .ad_from_tuvv(ad_from_tuvv),
    .seq_ctrl_sel(seq_ctrl_sel), .seq_cfg_sel(seq_cfg_sel), .seq_time_sel(seq_time_sel),
    .dac1_busy(dac1_busy), .dac_wr_valid(dac_wr_valid), .dac_wr_data(dac_wr_data),
    .seq_active(seq_active)
  );

  always #5 clk = ~clk;

  // DAC busy model: a 5-cycle pulse following each strobe.
  always @(negedge clk) begin
    if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    else if (rst_ && dac_wr_valid && busy_en) busy_cnt <= 5;
  end
  assign dac1_busy = (busy_cnt != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_ && dac_wr_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got %h expected no strobe", dac_wr_data);
      end else begin
        check("dac_wr_data", dac_wr_data, exp_q.pop_front());
      end
    end
  end

  function automatic logic [31:0] ctrl_word(input logic run, input logic lp, input logic tri_b);
    return {tb_tmpl, 7'd0, tri_b, lp, run};
  endfunction

  function automatic logic [31:0] cfg_word(input logic [9:0] s, input logic [9:0] e, input logic [5:0] st);
    return {6'd0, st, e, s};
  endfunction

  function automatic logic [31:0] exp_word(input logic [9:0] code);
    return {tb_tmpl, code};
  endfunction

  // Called at a negedge; the write is sampled on the following posedge.
  task automatic pci_write(input int sel, input logic [31:0] data);
    ad_to_tuvv   = data;
    rd_wr        = 1'b1;
    valid_pci    = 1'b1;
    seq_ctrl_sel = (sel == SEL_CTRL);
    seq_cfg_sel  = (sel == SEL_CFG);
    seq_time_sel = (sel == SEL_TIME);
    @(negedge clk);
    valid_pci = 1'b0;
    rd_wr = 1'b0;
    {seq_ctrl_sel, seq_cfg_sel, seq_time_sel} = 3'b000;
  endtask

  task automatic pci_read(input int sel, output logic [31:0] data);
    rd_wr        = 1'b0;
    seq_ctrl_sel = (sel == SEL_CTRL);
    seq_cfg_sel  = (sel == SEL_CFG);
    seq_time_sel = (sel == SEL_TIME);
    #1 data = ad_from_tuvv;
    {seq_ctrl_sel, seq_cfg_sel, seq_time_sel} = 3'b000;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 500; i++) begin
      if (!seq_active) break;
      @(negedge clk);
    end
    check("wait_idle", {31'd0, seq_active}, 32'd0);
  endtask

  task automatic wait_strobe();
    for (int i = 0; i < 200; i++) begin
      if (dac_wr_valid) break;
      @(negedge clk);
    end
    check("strobe_seen", {31'd0, dac_wr_valid}, 32'd1);
  endtask

  task automatic run_ramp(input logic [9:0] s, input logic [9:0] e, input logic [5:0] st,
                          input logic [15:0] dw, input logic lp, input logic tri_b);
    pci_write(SEL_CFG, cfg_word(s, e, st));
    pci_write(SEL_TIME, {16'd0, dw});
    pci_write(SEL_CTRL, ctrl_word(1'b1, lp, tri_b));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, dac_wr_valid}, 32'd0);
    check("rst_data", dac_wr_data, 32'd0);
    check("rst_active", {31'd0, seq_active}, 32'd0);
    rst_ = 1'b1;
    @(negedge clk);
    pci_read(SEL_CTRL, rd); check("rst_ctrl", rd, 32'd0);
    pci_read(SEL_CFG, rd);  check("rst_cfg", rd, 32'd0);
    pci_read(SEL_TIME, rd); check("rst_time", rd, 32'd0);

    // Up ramp 0x010..0x020 step 8, with strobe latency check.
    exp_q.push_back(exp_word(10'h010));
    exp_q.push_back(exp_word(10'h018));
    exp_q.push_back(exp_word(10'h020));
    run_ramp(10'h010, 10'h020, 6'd8, 16'd0, 1'b0, 1'b0);
    check("strobe_lat_first", {31'd0, dac_wr_valid}, 32'd0);
    @(negedge clk);
    check("strobe_lat_second", {31'd0, dac_wr_valid}, 32'd1);
    wait_idle();
    pci_read(SEL_CTRL, rd); check("t1_ctrl", rd, 32'h0000_0820);
    pci_read(SEL_CFG, rd);  check("t1_cfg", rd, cfg_word(10'h010, 10'h020, 6'd8));
    check("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // Clamp near full scale: 0x3F0 + 63 must clamp to 0x3FF.
    exp_q.push_back(exp_word(10'h3F0));
    exp_q.push_back(exp_word(10'h3FF));
    run_ramp(10'h3F0, 10'h3FF, 6'd63, 16'd3, 1'b0, 1'b0);
    wait_idle();
    pci_read(SEL_CTRL, rd); check("t2_ctrl", rd, 32'h0000_0BFF);
    pci_read(SEL_TIME, rd); check("t2_time", rd, 32'd3);
    check("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // Step 0 behaves as step 1.
    exp_q.push_back(exp_word(10'h005));
    exp_q.push_back(exp_word(10'h006));
    exp_q.push_back(exp_word(10'h007));
    run_ramp(10'h005, 10'h007, 6'd0, 16'd0, 1'b0, 1'b0);
    wait_idle();
    pci_read(SEL_CTRL, rd); check("t2b_ctrl", rd, 32'h0000_0807);
    check("t2b_q_empty", 32'(exp_q.size()), 32'd0);

    // Single triangle 0x100 -> 0x104 -> 0x100.
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(exp_word(10'h100));
    exp_q.push_back(exp_word(10'h102));
    exp_q.push_back(exp_word(10'h104));
    exp_q.push_back(exp_word(10'h102));
    exp_q.push_back(exp_word(10'h100));
    run_ramp(10'h100, 10'h104, 6'd2, 16'd1, 1'b0, 1'b1);
    wait_idle();
    pci_read(SEL_CTRL, rd); check("t3_ctrl", rd, 32'h0000_2900);
    check("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // Busy never rises: timeout sets err, no second strobe.
    busy_en = 1'b0;
    exp_q.push_back(exp_word(10'h050));
    run_ramp(10'h050, 10'h060, 6'd4, 16'd0, 1'b0, 1'b0);
    wait_idle();
    repeat (20) @(negedge clk);
    pci_read(SEL_CTRL, rd); check("t4_ctrl", rd, 32'h0000_1050);
    check("t4_q_empty", 32'(exp_q.size()), 32'd0);
    busy_en = 1'b1;

    // Looping sawtooth stopped during WAIT_HI; CFG/TIME writes while active are ignored.
    exp_q.push_back(exp_word(10'h200));
    exp_q.push_back(exp_word(10'h204));
    exp_q.push_back(exp_word(10'h200));
    run_ramp(10'h200, 10'h204, 6'd4, 16'd0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      wait_strobe();
      @(negedge clk);
    end
    pci_write(SEL_CTRL, ctrl_word(1'b0, 1'b1, 1'b0));
    check("t5_active_after_stop", {31'd0, seq_active}, 32'd1);
    pci_write(SEL_CFG, cfg_word(10'h001, 10'h002, 6'd1));
    pci_write(SEL_TIME, 32'd7);
    wait_idle();
    repeat (20) @(negedge clk);
    pci_read(SEL_CTRL, rd); check("t5_ctrl", rd, 32'h0000_0200);
    pci_read(SEL_CFG, rd);  check("t5_cfg", rd, cfg_word(10'h200, 10'h204, 6'd4));
    pci_read(SEL_TIME, rd); check("t5_time", rd, 32'd0);
    check("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in DWELL, then a fresh run from start.
    exp_q.push_back(exp_word(10'h030));
    run_ramp(10'h030, 10'h040, 6'd8, 16'd20, 1'b0, 1'b0);
    wait_strobe();
    repeat (10) @(negedge clk);
    check("t6_in_dwell", {31'd0, seq_active}, 32'd1);
    #2 rst_ = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, dac_wr_valid}, 32'd0);
    check("t6_rst_data", dac_wr_data, 32'd0);
    check("t6_rst_active", {31'd0, seq_active}, 32'd0);
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    pci_read(SEL_CFG, rd);  check("t6_cfg_cleared", rd, 32'd0);
    pci_read(SEL_CTRL, rd); check("t6_ctrl_cleared", rd, 32'd0);
    check("t6_q_empty_rst", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(exp_word(10'h030));
    exp_q.push_back(exp_word(10'h038));
    exp_q.push_back(exp_word(10'h040));
    run_ramp(10'h030, 10'h040, 6'd8, 16'd2, 1'b0, 1'b0);
    wait_idle();
    pci_read(SEL_CTRL, rd); check("t6_ctrl", rd, 32'h0000_0840);
    check("t6_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected summary");
    $fatal(1, "timeout");
  end
endmodule
